// File: rtl/key_event.sv
// key_event: turns the debounced key level into press / release / long-press /
// auto-repeat events and queues them as ASCII bytes for a UART transmitter.
//
// Events: 'P' (0x50) press, 'R' (0x52) release, 'L' (0x4C) long press,
//         'T' (0x54) auto-repeat after the long press.
// Ports:
//   clk         system clock, rising edge
//   nrst        asynchronous active-low reset
//   key_in      debounced key level (polarity set by ACTIVE_LOW)
//   ev_data     byte at the FIFO head (0x00 while the FIFO is empty)
//   ev_valid    FIFO not empty
//   ev_ready    consumer takes ev_data when ev_valid & ev_ready
//   key_pressed registered, polarity-normalised pressed state
//   drop_cnt    saturating count of events lost on a full FIFO
module key_event #(
    parameter int ACTIVE_LOW    = 1,
    parameter int LONG_CYCLES   = 13_500_000,
    parameter int REPEAT_CYCLES = 2_700_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       key_in,
    output logic [7:0] ev_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       key_pressed,
    output logic [7:0] drop_cnt
);

    localparam int MAXC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] LONG_TERM   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_TERM = CW'(REPEAT_CYCLES - 1);
    localparam logic          POL         = (ACTIVE_LOW != 0);

    localparam logic [7:0] CH_P = 8'h50;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_L = 8'h4C;
    localparam logic [7:0] CH_T = 8'h54;

    logic          pressed_now;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic          long_done, long_nxt;
    logic          ev_push;
    logic [7:0]    ev_byte;

    assign pressed_now = key_in ^ POL;

    // Event detection. Press/release are edges of pressed_now against the
    // registered state; hold events only exist while both are high, so at
    // most one event can fire per cycle.
    always_comb begin
        ev_push  = 1'b0;
        ev_byte  = 8'h00;
        hold_nxt = hold_cnt;
        long_nxt = long_done;
        if (pressed_now && !key_pressed) begin
            ev_push  = 1'b1;
            ev_byte  = CH_P;
            hold_nxt = '0;
            long_nxt = 1'b0;
        end else if (!pressed_now && key_pressed) begin
            ev_push  = 1'b1;
            ev_byte  = CH_R;
            hold_nxt = '0;
            long_nxt = 1'b0;
        end else if (pressed_now && key_pressed) begin
            if (!long_done && hold_cnt == LONG_TERM) begin
                ev_push  = 1'b1;
                ev_byte  = CH_L;
                hold_nxt = '0;
                long_nxt = 1'b1;
            end else if (long_done && hold_cnt == REPEAT_TERM) begin
                ev_push  = 1'b1;
                ev_byte  = CH_T;
                hold_nxt = '0;
            end else begin
                hold_nxt = hold_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            key_pressed <= 1'b0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
        end else begin
            key_pressed <= pressed_now;
            hold_cnt    <= hold_nxt;
            long_done   <= long_nxt;
        end
    end

    // 4-entry event FIFO
    logic [7:0] mem [4];
    logic [1:0] wptr, rptr;
    logic [2:0] count;
    logic       pop, full, accept, drop;

    assign ev_valid = (count != 3'd0);
    assign pop      = ev_valid & ev_ready;
    assign full     = (count == 3'd4);
    // A pop on the same edge frees the slot, so a push into a full FIFO
    // still lands when the consumer is draining.
    assign accept   = ev_push & (~full | pop);
    assign drop     = ev_push & full & ~pop;
    assign ev_data  = ev_valid ? mem[rptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= ev_byte;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            count <= count + {2'b00, accept} - {2'b00, pop};
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
